// File: rtl/issue_stage.sv
// Issue stage: per-register scoreboard, control-shadow and divider wait,
// operand select with writeback bypass, registered issue bundle.
// Latency: 1 cycle from accept to out_valid. Backpressure: stall holds the
// bundle and blocks issue; in_ready is combinational.
module issue_stage #(
  parameter int XLEN         = 32,
  parameter int NREGS        = 32,
  parameter int CTRL_PENALTY = 3,
  localparam int RA          = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RA-1:0]   in_rs1,
  input  logic [RA-1:0]   in_rs2,
  input  logic            in_use_rs1,
  input  logic            in_use_rs2,
  input  logic [RA-1:0]   in_rd,
  input  logic            in_reg_we,
  input  logic [1:0]      in_class,
  input  logic            in_src_a,
  input  logic            in_src_b,
  output logic [RA-1:0]   rf_raddr_a,
  output logic [RA-1:0]   rf_raddr_b,
  input  logic [XLEN-1:0] rf_rdata_a,
  input  logic [XLEN-1:0] rf_rdata_b,
  input  logic            wb_we,
  input  logic [RA-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_wdata,
  input  logic            div_ready,
  input  logic            flush,
  input  logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_alu_a,
  output logic [XLEN-1:0] out_alu_b,
  output logic [XLEN-1:0] out_store_data,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [RA-1:0]   out_rd,
  output logic            out_reg_we,
  output logic [1:0]      out_class,
  output logic            raw_stall,
  output logic            busy
);

  // Shadow counter only needs to hold CTRL_PENALTY; keep at least one bit.
  localparam int CW = (CTRL_PENALTY > 0) ? $clog2(CTRL_PENALTY + 1) : 1;

  localparam logic [1:0] CLS_CTRL = 2'd2;
  localparam logic [1:0] CLS_DIV  = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CTRL_WAIT = 2'd1,
    DIV_WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREGS-1:0] pend_q, pend_d;

  logic            issue;
  logic            wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
  logic [XLEN-1:0] op_a, op_b;

  logic            out_valid_q, out_reg_we_q;
  logic [XLEN-1:0] out_alu_a_q, out_alu_b_q, out_store_data_q, out_pc_q, out_imm_q;
  logic [RA-1:0]   out_rd_q;
  logic [1:0]      out_class_q;

  assign rf_raddr_a = in_rs1;
  assign rf_raddr_b = in_rs2;

  // A writeback landing this cycle both forwards its data and retires the hazard.
  assign wb_hit_rs1 = wb_we && (wb_rd == in_rs1);
  assign wb_hit_rs2 = wb_we && (wb_rd == in_rs2);
  assign wb_hit_rd  = wb_we && (wb_rd == in_rd);

  // Operand fetch: x0 is hard zero regardless of what the register file returns.
  always_comb begin
    op_a = rf_rdata_a;
    op_b = rf_rdata_b;
    if (in_rs1 == '0)    op_a = '0;
    else if (wb_hit_rs1) op_a = wb_wdata;
    if (in_rs2 == '0)    op_b = '0;
    else if (wb_hit_rs2) op_b = wb_wdata;
  end

  // RAW on either used source, plus WAW on the destination.
  always_comb begin
    raw_stall = in_valid &&
                ((in_use_rs1 && pend_q[in_rs1] && !wb_hit_rs1) ||
                 (in_use_rs2 && pend_q[in_rs2] && !wb_hit_rs2) ||
                 (in_reg_we  && pend_q[in_rd]  && !wb_hit_rd));
  end

  // FSM outputs: accept only from IDLE with no hold, redirect or hazard.
  always_comb begin
    busy     = (state_q != IDLE);
    in_ready = (state_q == IDLE) && !stall && !flush && !raw_stall;
  end

  assign issue = in_valid && in_ready;

  // FSM next state: control shadow counts down even under stall; divider waits for div_ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          if ((in_class == CLS_CTRL) && (CTRL_PENALTY > 0)) begin
            state_d = CTRL_WAIT;
            cnt_d   = CW'(CTRL_PENALTY);
          end else if (in_class == CLS_DIV) begin
            state_d = DIV_WAIT;
          end
        end
      end
      CTRL_WAIT: begin
        if (flush || (cnt_q <= CW'(1))) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DIV_WAIT: begin
        if (div_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scoreboard update: a new producer overrides a same-cycle writeback of that register.
  always_comb begin
    pend_d = pend_q;
    if (wb_we) pend_d[wb_rd] = 1'b0;
    if (issue && in_reg_we && (in_rd != '0)) pend_d[in_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Scoreboard register; flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // Issue bundle: load on issue, hold under stall, otherwise drop valid/we but keep data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q      <= 1'b0;
      out_reg_we_q     <= 1'b0;
      out_alu_a_q      <= '0;
      out_alu_b_q      <= '0;
      out_store_data_q <= '0;
      out_pc_q         <= '0;
      out_imm_q        <= '0;
      out_rd_q         <= '0;
      out_class_q      <= '0;
    end else if (!stall) begin
      if (issue) begin
        out_valid_q      <= 1'b1;
        out_reg_we_q     <= in_reg_we;
        out_alu_a_q      <= in_src_a ? in_pc : op_a;
        out_alu_b_q      <= in_src_b ? in_imm : op_b;
        out_store_data_q <= op_b;
        out_pc_q         <= in_pc;
        out_imm_q        <= in_imm;
        out_rd_q         <= in_rd;
        out_class_q      <= in_class;
      end else begin
        out_valid_q  <= 1'b0;
        out_reg_we_q <= 1'b0;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_reg_we     = out_reg_we_q;
  assign out_alu_a      = out_alu_a_q;
  assign out_alu_b      = out_alu_b_q;
  assign out_store_data = out_store_data_q;
  assign out_pc         = out_pc_q;
  assign out_imm        = out_imm_q;
  assign out_rd         = out_rd_q;
  assign out_class      = out_class_q;

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: directed scenarios with literal expectations,
// then randomized traffic; a cycle-level model checks every output each negedge.
module tb_issue_stage;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int PEN   = 3;
  localparam int RA    = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_imm;
  logic [RA-1:0]   in_rs1, in_rs2, in_rd;
  logic            in_use_rs1, in_use_rs2, in_reg_we;
  logic [1:0]      in_class;
  logic            in_src_a, in_src_b;
  logic [RA-1:0]   rf_raddr_a, rf_raddr_b;
  logic [XLEN-1:0] rf_rdata_a, rf_rdata_b;
  logic            wb_we;
  logic [RA-1:0]   wb_rd;
  logic [XLEN-1:0] wb_wdata;
  logic            div_ready, flush, stall;
  logic            out_valid, out_reg_we;
  logic [XLEN-1:0] out_alu_a, out_alu_b, out_store_data, out_pc, out_imm;
  logic [RA-1:0]   out_rd;
  logic [1:0]      out_class;
  logic            raw_stall, busy;

  issue_stage #(.XLEN(XLEN), .NREGS(NREGS), .CTRL_PENALTY(PEN)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_reg_we(in_reg_we), .in_class(in_class),
    .in_src_a(in_src_a), .in_src_b(in_src_b),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .div_ready(div_ready), .flush(flush), .stall(stall),
    .out_valid(out_valid), .out_alu_a(out_alu_a), .out_alu_b(out_alu_b),
    .out_store_data(out_store_data), .out_pc(out_pc), .out_imm(out_imm),
    .out_rd(out_rd), .out_reg_we(out_reg_we), .out_class(out_class),
    .raw_stall(raw_stall), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set, shadow cycles remaining, divider-wait flag, expected bundle.
  bit              m_pend [NREGS];
  int              m_ctrl_left;
  bit              m_div;
  logic            m_valid, m_we;
  logic [XLEN-1:0] m_a, m_b, m_sd, m_pc, m_imm;
  logic [RA-1:0]   m_rd;
  logic [1:0]      m_cls;

  task automatic m_clear();
    for (int r = 0; r < NREGS; r++) m_pend[r] = 1'b0;
    m_ctrl_left = 0;
    m_div   = 1'b0;
    m_valid = 1'b0; m_we = 1'b0;
    m_a = '0; m_b = '0; m_sd = '0; m_pc = '0; m_imm = '0;
    m_rd = '0; m_cls = '0;
  endtask

  function automatic bit hazard(input logic [RA-1:0] r);
    return (r != 0) && m_pend[r] && !(wb_we && wb_rd == r);
  endfunction

  function automatic logic [XLEN-1:0] operand(input logic [RA-1:0] r, input logic [XLEN-1:0] rf);
    if (r == 0) return '0;
    if (wb_we && wb_rd == r) return wb_wdata;
    return rf;
  endfunction

  // Compare process: check every output against the model, then advance the model one cycle.
  always @(negedge clk) begin
    bit e_busy, e_raw, e_ready, iss;
    logic [XLEN-1:0] oa, ob;
    if (reset) m_clear();
    e_busy  = (m_ctrl_left > 0) || m_div;
    e_raw   = in_valid && ((in_use_rs1 && hazard(in_rs1)) ||
                           (in_use_rs2 && hazard(in_rs2)) ||
                           (in_reg_we  && hazard(in_rd)));
    e_ready = !e_busy && !stall && !flush && !e_raw;
    chk("busy", busy, e_busy);
    chk("raw_stall", raw_stall, e_raw);
    chk("in_ready", in_ready, e_ready);
    chk("rf_raddr_a", rf_raddr_a, in_rs1);
    chk("rf_raddr_b", rf_raddr_b, in_rs2);
    chk("out_valid", out_valid, m_valid);
    chk("out_reg_we", out_reg_we, m_we);
    chk("out_alu_a", out_alu_a, m_a);
    chk("out_alu_b", out_alu_b, m_b);
    chk("out_store_data", out_store_data, m_sd);
    chk("out_pc", out_pc, m_pc);
    chk("out_imm", out_imm, m_imm);
    chk("out_rd", out_rd, m_rd);
    chk("out_class", out_class, m_cls);
    if (!reset) begin
      iss = in_valid && e_ready;
      oa  = operand(in_rs1, rf_rdata_a);
      ob  = operand(in_rs2, rf_rdata_b);
      if (!stall) begin
        if (iss) begin
          m_valid = 1'b1; m_we = in_reg_we;
          m_a = in_src_a ? in_pc : oa;
          m_b = in_src_b ? in_imm : ob;
          m_sd = ob; m_pc = in_pc; m_imm = in_imm; m_rd = in_rd; m_cls = in_class;
        end else begin
          m_valid = 1'b0; m_we = 1'b0;
        end
      end
      if (wb_we) m_pend[wb_rd] = 1'b0;
      if (iss && in_reg_we && in_rd != 0) m_pend[in_rd] = 1'b1;
      if (m_ctrl_left > 0) m_ctrl_left = flush ? 0 : m_ctrl_left - 1;
      if (m_div && div_ready) m_div = 1'b0;
      if (iss && in_class == 2'd2) m_ctrl_left = PEN;
      if (iss && in_class == 2'd3) m_div = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_pc = 32'h1000; in_imm = 32'h10;
    in_rs1 = 0; in_rs2 = 0; in_use_rs1 = 0; in_use_rs2 = 0;
    in_rd = 0; in_reg_we = 0; in_class = 0; in_src_a = 0; in_src_b = 0;
    rf_rdata_a = 32'h1234; rf_rdata_b = 32'h5678;
    wb_we = 0; wb_rd = 0; wb_wdata = 0;
    div_ready = 0; flush = 0; stall = 0;
  endtask

  task automatic set_instr(input logic [1:0] cls, input logic [RA-1:0] rs1, input logic u1,
                           input logic [RA-1:0] rd, input logic we);
    in_valid = 1; in_class = cls; in_rs1 = rs1; in_use_rs1 = u1;
    in_rs2 = 0; in_use_rs2 = 0; in_rd = rd; in_reg_we = we;
    in_src_a = 0; in_src_b = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;

    // Reset in the middle of a divide with x5 pending.
    set_instr(2'd0, 0, 0, 5, 1);
    at_neg(); chk("t1_alu_ready", in_ready, 1'b1);
    tick();
    set_instr(2'd3, 0, 0, 6, 1);
    at_neg(); chk("t1_div_ready", in_ready, 1'b1);
    tick();
    idle_inputs();
    at_neg(); chk("t1_busy_div", busy, 1'b1);
    tick();
    reset = 1;
    at_neg(); chk("t1_rst_valid", out_valid, 1'b0); chk("t1_rst_busy", busy, 1'b0);
    chk("t1_rst_alu_a", out_alu_a, 32'h0);
    tick();
    reset = 0;
    set_instr(2'd0, 5, 1, 5, 1);
    at_neg(); chk("t1_post_ready", in_ready, 1'b1); chk("t1_post_raw", raw_stall, 1'b0);
    tick();

    // RAW on x5 resolved by same-cycle writeback with bypass.
    set_instr(2'd0, 5, 1, 0, 0);
    at_neg(); chk("t2_raw", raw_stall, 1'b1); chk("t2_ready", in_ready, 1'b0);
    tick();
    wb_we = 1; wb_rd = 5; wb_wdata = 32'hDEAD;
    at_neg(); chk("t2_wb_raw", raw_stall, 1'b0); chk("t2_wb_ready", in_ready, 1'b1);
    tick();
    idle_inputs();
    at_neg(); chk("t2_out_valid", out_valid, 1'b1); chk("t2_bypass", out_alu_a, 32'hDEAD);
    tick();

    // x0 is never pending and always reads zero.
    set_instr(2'd0, 0, 0, 0, 1);
    tick();
    set_instr(2'd0, 0, 1, 0, 0);
    rf_rdata_a = 32'hFFFF_FFFF;
    at_neg(); chk("t5_raw", raw_stall, 1'b0); chk("t5_ready", in_ready, 1'b1);
    tick();
    idle_inputs();
    at_neg(); chk("t5_zero", out_alu_a, 32'h0);
    tick();

    // Control shadow: three blocked cycles, then a flush cuts the second shadow short.
    set_instr(2'd2, 0, 0, 0, 0);
    at_neg(); chk("t3_ctrl_ready", in_ready, 1'b1);
    tick();
    set_instr(2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      at_neg(); chk("t3_shadow", in_ready, 1'b0);
      tick();
    end
    at_neg(); chk("t3_shadow_end", in_ready, 1'b1);
    tick();
    set_instr(2'd2, 0, 0, 0, 0);
    at_neg(); chk("t3_ctrl2_ready", in_ready, 1'b1);
    tick();
    set_instr(2'd0, 0, 0, 0, 0);
    at_neg(); chk("t3_sh1", in_ready, 1'b0);
    tick();
    flush = 1;
    at_neg(); chk("t3_flush_cycle", in_ready, 1'b0);
    tick();
    flush = 0;
    at_neg(); chk("t3_after_flush", in_ready, 1'b1);
    tick();

    // Divider wait ends the cycle after div_ready.
    set_instr(2'd3, 0, 0, 0, 0);
    at_neg(); chk("t4_div_ready", in_ready, 1'b1);
    tick();
    set_instr(2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      div_ready = (i == 6);
      at_neg(); chk("t4_busy", busy, 1'b1); chk("t4_blocked", in_ready, 1'b0);
      tick();
    end
    div_ready = 0;
    at_neg(); chk("t4_done_busy", busy, 1'b0); chk("t4_done_ready", in_ready, 1'b1);
    tick();

    // Downstream stall holds the bundle; release does not duplicate it.
    set_instr(2'd0, 0, 0, 0, 0);
    in_pc = 32'h100;
    tick();
    in_pc = 32'h200;
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      at_neg(); chk("t6_ready", in_ready, 1'b0); chk("t6_hold_valid", out_valid, 1'b1);
      chk("t6_hold_pc", out_pc, 32'h100);
      tick();
    end
    stall = 0;
    in_valid = 0;
    at_neg(); chk("t6_release_valid", out_valid, 1'b1);
    tick();
    at_neg(); chk("t6_no_dup", out_valid, 1'b0); chk("t6_pc_kept", out_pc, 32'h100);
    tick();

    // Randomized traffic on a narrow register window so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_pc      = $urandom;
      in_imm     = $urandom;
      in_rs1     = RA'($urandom_range(0, 7));
      in_rs2     = RA'($urandom_range(0, 7));
      in_rd      = RA'($urandom_range(0, 7));
      in_use_rs1 = $urandom_range(0, 1);
      in_use_rs2 = $urandom_range(0, 1);
      in_reg_we  = $urandom_range(0, 1);
      in_class   = 2'($urandom_range(0, 3));
      in_src_a   = $urandom_range(0, 1);
      in_src_b   = $urandom_range(0, 1);
      rf_rdata_a = $urandom;
      rf_rdata_b = $urandom;
      wb_we      = ($urandom_range(0, 1) == 0);
      wb_rd      = RA'($urandom_range(0, 7));
      wb_wdata   = $urandom;
      div_ready  = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 7) == 0);
      stall      = ($urandom_range(0, 4) == 0);
      tick();
    end
    reset = 0;
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Parametrised successor to the core decode/issue stage.
- Replaces the fixed per-class stall counters with a per-register scoreboard, a configurable control-shadow length and a divider wait.
- Issues only when operands are hazard-free, selects ALU operands, and registers the issue bundle for the execute stage.
- Sits between the instruction decoder (control fields) and execute; reads the register file combinationally and snoops writeback.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural register count (power of 2); RA = clog2(NREGS).
- CTRL_PENALTY, 3, cycles issue is blocked after a branch/jal/jalr issues; 0 = no shadow.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle (combinational)
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  decoded immediate
- in_rs1, in_rs2  in  RA  source register indices
- in_use_rs1, in_use_rs2  in  1  source register is actually read
- in_rd  in  RA  destination index
- in_reg_we  in  1  instruction writes rd
- in_class  in  2  0=ALU, 1=LOAD, 2=CTRL, 3=DIV
- in_src_a, in_src_b  in  1  0 = register operand; 1 = pc (a) or imm (b)
- rf_raddr_a, rf_raddr_b  out  RA  register file read addresses (= in_rs1, in_rs2)
- rf_rdata_a, rf_rdata_b  in  XLEN  combinational register file read data
- wb_we  in  1  writeback valid
- wb_rd  in  RA  writeback register
- wb_wdata  in  XLEN  writeback data
- div_ready  in  1  divider result complete
- flush  in  1  redirect from branch resolution
- stall  in  1  downstream hold
- out_valid  out  1  issue bundle valid
- out_alu_a, out_alu_b, out_store_data, out_pc, out_imm  out  XLEN  registered operands
- out_rd  out  RA  registered destination
- out_reg_we  out  1  registered write enable
- out_class  out  2  registered class
- raw_stall  out  1  issue blocked by scoreboard this cycle
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, any cycle, mid-operation included):
  - all out_* = 0; scoreboard cleared; state = IDLE; shadow counter = 0.
  - No partially issued bundle survives reset.
- Register 0:
  - Always reads 0.
  - Never marked pending.
  - Writeback to register 0 is ignored.
- Operand read with bypass: if wb_we && wb_rd == rsN && rsN != 0, the operand is wb_wdata; otherwise it is rf_rdata_N.
- Pending check:
  - pend_eff[r] = pending[r] && !(wb_we && wb_rd == r), so a same-cycle writeback resolves the hazard.
  - raw_stall = in_valid && ((in_use_rs1 && pend_eff[in_rs1]) || (in_use_rs2 && pend_eff[in_rs2]) || (in_reg_we && pend_eff[in_rd])).
  - The last term is the WAW check.
- Issue condition: in_ready = (state == IDLE) && !stall && !flush && !raw_stall. An instruction issues when in_valid && in_ready.
- Scoreboard:
  - On issue with in_reg_we && in_rd != 0, set pending[in_rd].
  - On wb_we, clear pending[wb_rd].
  - If both hit the same register in one cycle, the set wins.
- Output register, 1-cycle latency:
  - On issue: out_alu_a = src_a ? in_pc : opA; out_alu_b = src_b ? in_imm : opB; out_store_data = opB; remaining fields copied; out_valid = 1.
  - When stall = 1: all out_* hold.
  - Otherwise, with no issue: out_valid = 0 and out_reg_we = 0. The data fields hold.
- State machine: IDLE, CTRL_WAIT, DIV_WAIT.
  - IDLE → CTRL_WAIT: issue of CTRL with CTRL_PENALTY > 0; counter loads CTRL_PENALTY.
  - IDLE → DIV_WAIT: issue of DIV.
  - CTRL_WAIT: counter decrements each cycle regardless of stall; at 1 → IDLE. flush → IDLE next cycle (counter cleared).
  - DIV_WAIT: div_ready → IDLE next cycle. flush has no effect. div_ready while not in DIV_WAIT is ignored.
  - In CTRL_WAIT or DIV_WAIT, in_ready = 0.
- Flush:
  - Blocks issue in the cycle it is asserted.
  - Never clears scoreboard bits or the output register.
- Loads: no fixed stall; a dependent instruction waits on the scoreboard until its writeback.

Test Plan:
- Reset mid DIV_WAIT with pending[5] set → all outputs 0, busy = 0, in_ready = 1 next cycle with in_valid = 1, no hazards.
- Issue ALU rd=5, then an instruction with in_use_rs1=1, rs1=5 → raw_stall = 1 and in_ready = 0. Then wb_we=1, wb_rd=5, wb_wdata=0xDEAD in the same cycle → issues with out_alu_a = 0xDEAD one cycle later.
- CTRL issue with CTRL_PENALTY=3 → in_ready = 0 for exactly 3 cycles, then 1. Repeat with flush in the 2nd shadow cycle → in_ready = 0 during the flush cycle, 1 the following cycle.
- DIV issue, div_ready asserted after 7 cycles → busy high 7 cycles; the next instruction issues the cycle after div_ready.
- Issue rd=0 followed by a dependent read of x0 → no raw_stall; operand = 0 even if rf_rdata_a = 0xFFFFFFFF.
- stall = 1 for 2 cycles after an issue → out_* stable, in_ready = 0. Release → out_valid = 0 the next cycle (no duplicate issue).
